// File: rtl/fp_mp_pkg.sv
// Shared definitions for the multi-precision FP datapath: formats, mode encoding,
// unpack-stage state enum and class-flag payload.
package fp_mp_pkg;

  // Internal unpacked operand widths
  localparam int unsigned MANT_W      = 24;
  localparam int unsigned EXP_W       = 8;

  // Native format field widths
  localparam int unsigned SGL_EXP_W   = 8;
  localparam int unsigned SGL_FRAC_W  = 23;
  localparam int unsigned HALF_EXP_W  = 5;
  localparam int unsigned HALF_FRAC_W = 10;

  // Packed word geometry
  localparam int unsigned WORD_W      = 32;
  localparam int unsigned HALF_W      = 16;

  // Mode encoding carried with each word / beat
  localparam logic SINGLE_MODE = 1'b0;
  localparam logic HALF_MODE   = 1'b1;

  // Unpack stage output-register occupancy
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_SGL   = 2'd1,
    ST_HLO   = 2'd2,
    ST_HHI   = 2'd3
  } state_t;

  // One-hot class flags; all zero means a normal number
  typedef struct packed {
    logic zero;
    logic inf;
    logic nan;
    logic sub;
  } fp_class_t;

endpackage

// File: rtl/fp_field_classify.sv
// Combinational extract / classify / align for one operand (single or half).
// Optional build macro: FP_UNPACK_FTZ_EN flushes subnormals to signed zero.
module fp_field_classify
  import fp_mp_pkg::*;
(
  input  logic              mode,
  input  logic [WORD_W-1:0] operand,
  output logic              sign_c,
  output logic [EXP_W-1:0]  exp_c,
  output logic [MANT_W-1:0] mant_c,
  output fp_class_t         cls_c
);

  logic [EXP_W-1:0]  exp_raw;
  logic [MANT_W-2:0] frac_al;
  logic              exp_ones;
  logic              exp_zero;
  logic              frac_zero;

  // Pull the native fields and left-align the fraction under the hidden bit
  always_comb begin
    sign_c   = 1'b0;
    exp_raw  = '0;
    frac_al  = '0;
    exp_ones = 1'b0;
    if (mode == HALF_MODE) begin
      sign_c   = operand[HALF_W-1];
      exp_raw  = EXP_W'(operand[HALF_FRAC_W +: HALF_EXP_W]);
      frac_al  = {operand[HALF_FRAC_W-1:0], {(SGL_FRAC_W-HALF_FRAC_W){1'b0}}};
      exp_ones = &operand[HALF_FRAC_W +: HALF_EXP_W];
    end else begin
      sign_c   = operand[WORD_W-1];
      exp_raw  = EXP_W'(operand[SGL_FRAC_W +: SGL_EXP_W]);
      frac_al  = operand[SGL_FRAC_W-1:0];
      exp_ones = &operand[SGL_FRAC_W +: SGL_EXP_W];
    end
  end

  assign exp_zero  = (exp_raw == '0);
  assign frac_zero = (frac_al == '0);

  // Classify and build the internal exponent / mantissa
  always_comb begin
    cls_c  = '0;
    exp_c  = exp_raw;
    mant_c = {1'b1, frac_al};
    if (exp_zero) begin
      if (frac_zero) begin
        cls_c.zero = 1'b1;
        exp_c      = '0;
        mant_c     = '0;
      end else begin
`ifdef FP_UNPACK_FTZ_EN
        cls_c.zero = 1'b1;
        exp_c      = '0;
        mant_c     = '0;
`else
        // Subnormal: effective exponent is 1, no hidden bit
        cls_c.sub  = 1'b1;
        exp_c      = EXP_W'(1);
        mant_c     = {1'b0, frac_al};
`endif
      end
    end else if (exp_ones) begin
      if (frac_zero) begin
        cls_c.inf = 1'b1;
      end else begin
        cls_c.nan = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fp_unpack_stage.sv
// Operand unpacker: one packed word in (one single or two halves), one unpacked
// operand per beat out, registered output with a half-mode serializer.
// Optional build macro: FP_UNPACK_FTZ_EN (subnormal flush-to-zero, in fp_field_classify).
module fp_unpack_stage
  import fp_mp_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WORD_W-1:0] in_data,
  input  logic              in_mode,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_sign,
  output logic [EXP_W-1:0]  out_exp,
  output logic [MANT_W-1:0] out_mant,
  output logic              out_mode,
  output logic              out_last,
  output logic              out_zero,
  output logic              out_inf,
  output logic              out_nan,
  output logic              out_sub
);

  state_t            state_q;
  state_t            state_d;
  logic              accept;
  logic              load_word;
  logic              load_hi;
  logic              src_mode;
  logic [WORD_W-1:0] src_word;

  logic              valid_q;
  logic              last_q;
  logic              mode_q;
  logic              sign_q;
  logic [EXP_W-1:0]  exp_q;
  logic [MANT_W-1:0] mant_q;
  fp_class_t         cls_q;
  logic [HALF_W-1:0] hi_q;

  logic              sign_c;
  logic [EXP_W-1:0]  exp_c;
  logic [MANT_W-1:0] mant_c;
  fp_class_t         cls_c;

  // Accept only into an empty register or when the final beat is leaving
  assign in_ready = (state_q == ST_EMPTY) | (out_ready & last_q & valid_q);
  assign accept   = in_valid & in_ready;

  // Next-state and load controls
  always_comb begin
    state_d   = state_q;
    load_word = accept;
    load_hi   = 1'b0;
    case (state_q)
      ST_EMPTY: begin
        if (accept) begin
          state_d = (in_mode == HALF_MODE) ? ST_HLO : ST_SGL;
        end
      end
      ST_SGL, ST_HHI: begin
        if (out_ready) begin
          if (accept) begin
            state_d = (in_mode == HALF_MODE) ? ST_HLO : ST_SGL;
          end else begin
            state_d = ST_EMPTY;
          end
        end
      end
      ST_HLO: begin
        if (out_ready) begin
          state_d = ST_HHI;
          load_hi = 1'b1;
        end
      end
      default: begin
        state_d = ST_EMPTY;
      end
    endcase
  end

  // Classifier source: buffered hi half when advancing HLO->HHI, else the new word
  always_comb begin
    src_mode = in_mode;
    src_word = in_data;
    if (load_hi) begin
      src_mode = HALF_MODE;
      src_word = {{(WORD_W-HALF_W){1'b0}}, hi_q};
    end
  end

  fp_field_classify u_classify (
    .mode    (src_mode),
    .operand (src_word),
    .sign_c  (sign_c),
    .exp_c   (exp_c),
    .mant_c  (mant_c),
    .cls_c   (cls_c)
  );

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  // Output register and hi-half buffer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      mode_q  <= 1'b0;
      sign_q  <= 1'b0;
      exp_q   <= '0;
      mant_q  <= '0;
      cls_q   <= '0;
      hi_q    <= '0;
    end else begin
      valid_q <= (state_d != ST_EMPTY);
      last_q  <= (state_d == ST_SGL) || (state_d == ST_HHI);
      if (load_word || load_hi) begin
        mode_q <= src_mode;
        sign_q <= sign_c;
        exp_q  <= exp_c;
        mant_q <= mant_c;
        cls_q  <= cls_c;
      end
      if (load_word && (in_mode == HALF_MODE)) begin
        hi_q <= in_data[WORD_W-1:HALF_W];
      end
    end
  end

  assign out_valid = valid_q;
  assign out_last  = last_q;
  assign out_mode  = mode_q;
  assign out_sign  = sign_q;
  assign out_exp   = exp_q;
  assign out_mant  = mant_q;
  assign out_zero  = cls_q.zero;
  assign out_inf   = cls_q.inf;
  assign out_nan   = cls_q.nan;
  assign out_sub   = cls_q.sub;

endmodule

// File: tb/tb_fp_unpack_stage.sv
// Bench for fp_unpack_stage: directed plan items plus randomized traffic against
// a queue-of-expected-beats reference model.
module tb_fp_unpack_stage;
  import fp_mp_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        in_mode;
  logic        out_valid;
  logic        out_ready;
  logic        out_sign;
  logic [7:0]  out_exp;
  logic [23:0] out_mant;
  logic        out_mode;
  logic        out_last;
  logic        out_zero;
  logic        out_inf;
  logic        out_nan;
  logic        out_sub;

  // {sign, exp, mant, mode, last, zero, inf, nan, sub}
  typedef logic [38:0] beat_t;

  int    n_checks = 0;
  int    n_fail   = 0;
  beat_t exp_q[$];

  fp_unpack_stage dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_mode   (in_mode),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sign  (out_sign),
    .out_exp   (out_exp),
    .out_mant  (out_mant),
    .out_mode  (out_mode),
    .out_last  (out_last),
    .out_zero  (out_zero),
    .out_inf   (out_inf),
    .out_nan   (out_nan),
    .out_sub   (out_sub)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, want, $time);
    end
  endtask

  function automatic beat_t dut_beat();
    return {out_sign, out_exp, out_mant, out_mode, out_last,
            out_zero, out_inf, out_nan, out_sub};
  endfunction

  // Reference decode from IEEE field rules using plain integer arithmetic
  function automatic beat_t ref_beat(input logic half, input logic [31:0] w, input logic last);
    int unsigned fw, ew, frac, expf, s, emax, e_o, m_o;
    logic [3:0]  fl;
    fw   = half ? 10 : 23;
    ew   = half ? 5 : 8;
    frac = w & ((32'd1 << fw) - 1);
    expf = (w >> fw) & ((32'd1 << ew) - 1);
    s    = (w >> (fw + ew)) & 1;
    emax = (32'd1 << ew) - 1;
    fl   = 4'b0000;
    e_o  = expf;
    m_o  = (32'd1 << 23) + (frac << (23 - fw));
    if (expf == 0 && frac == 0) begin
      fl = 4'b1000; e_o = 0; m_o = 0;
    end else if (expf == 0) begin
`ifdef FP_UNPACK_FTZ_EN
      fl = 4'b1000; e_o = 0; m_o = 0;
`else
      fl = 4'b0001; e_o = 1; m_o = frac << (23 - fw);
`endif
    end else if (expf == emax) begin
      fl = (frac == 0) ? 4'b0100 : 4'b0010;
    end
    return {s[0], e_o[7:0], m_o[23:0], half, last, fl};
  endfunction

  // One cycle: drive after negedge, check against the model, advance the model
  task automatic step(input logic v, input logic [31:0] d, input logic m, input logic r);
    logic want_rdy;
    in_valid  = v;
    in_data   = d;
    in_mode   = m;
    out_ready = r;
    #1;
    want_rdy = (exp_q.size() == 0) || (exp_q.size() == 1 && r);
    check("in_ready", 64'(in_ready), 64'(want_rdy));
    check("out_valid", 64'(out_valid), 64'(exp_q.size() != 0));
    if (exp_q.size() != 0) begin
      check("beat", 64'(dut_beat()), 64'(exp_q[0]));
      if (r) void'(exp_q.pop_front());
    end
    if (v && want_rdy) begin
      if (m == HALF_MODE) begin
        exp_q.push_back(ref_beat(1'b1, {16'h0, d[15:0]}, 1'b0));
        exp_q.push_back(ref_beat(1'b1, {16'h0, d[31:16]}, 1'b1));
      end else begin
        exp_q.push_back(ref_beat(1'b0, d, 1'b1));
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drain();
    for (int i = 0; i < 3; i++) step(1'b0, 32'h0, SINGLE_MODE, 1'b1);
  endtask

  function automatic logic [31:0] rand_word();
    logic [31:0] d;
    d = $urandom;
    case ($urandom_range(0, 4))
      0: begin d[30:23] = 8'h00; d[14:10] = 5'h00; end
      1: begin d[30:23] = 8'hFF; d[14:10] = 5'h1F; end
      2: begin d[22:0] = 23'h0; d[9:0] = 10'h0; end
      3: begin d[30:0] = 31'h0; d[14:0] = 15'h0; end
      default: ;
    endcase
    return d;
  endfunction

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = 32'h0;
    in_mode   = SINGLE_MODE;
    out_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_valid", 64'(out_valid), 64'd0);
    check("rst_ready", 64'(in_ready), 64'd1);
    check("rst_data", 64'(dut_beat()), 64'd0);
    rst_n = 1'b1;

    // Single 1.0
    step(1'b1, 32'h3F800000, SINGLE_MODE, 1'b1);
    check("one", 64'(dut_beat()), 64'({1'b0, 8'h7F, 24'h800000, SINGLE_MODE, 1'b1, 4'b0000}));
    step(1'b0, 32'h0, SINGLE_MODE, 1'b1);

    // Half pair: lo = 1.0, hi = -2.0
    step(1'b1, 32'hC0003C00, HALF_MODE, 1'b1);
    check("half_lo", 64'(dut_beat()), 64'({1'b0, 8'h0F, 24'h800000, HALF_MODE, 1'b0, 4'b0000}));
    check("half_lo_rdy", 64'(in_ready), 64'd0);
    step(1'b0, 32'h0, SINGLE_MODE, 1'b1);
    check("half_hi", 64'(dut_beat()), 64'({1'b1, 8'h10, 24'h800000, HALF_MODE, 1'b1, 4'b0000}));
    step(1'b0, 32'h0, SINGLE_MODE, 1'b1);

    // Specials
    step(1'b1, 32'h7FC00000, SINGLE_MODE, 1'b1);
    check("nan", 64'(dut_beat()), 64'({1'b0, 8'hFF, 24'hC00000, SINGLE_MODE, 1'b1, 4'b0010}));
    step(1'b1, 32'hFF800000, SINGLE_MODE, 1'b1);
    check("inf", 64'(dut_beat()), 64'({1'b1, 8'hFF, 24'h800000, SINGLE_MODE, 1'b1, 4'b0100}));
    step(1'b1, 32'h00000001, SINGLE_MODE, 1'b1);
`ifdef FP_UNPACK_FTZ_EN
    check("sgl_sub", 64'(dut_beat()), 64'({1'b0, 8'h00, 24'h000000, SINGLE_MODE, 1'b1, 4'b1000}));
`else
    check("sgl_sub", 64'(dut_beat()), 64'({1'b0, 8'h01, 24'h000001, SINGLE_MODE, 1'b1, 4'b0001}));
`endif
    step(1'b1, 32'h00000001, HALF_MODE, 1'b1);
`ifdef FP_UNPACK_FTZ_EN
    check("half_sub", 64'(dut_beat()), 64'({1'b0, 8'h00, 24'h000000, HALF_MODE, 1'b0, 4'b1000}));
`else
    check("half_sub", 64'(dut_beat()), 64'({1'b0, 8'h01, 24'h002000, HALF_MODE, 1'b0, 4'b0001}));
`endif
    drain();

    // Backpressure on a half word, with a competing valid input held off
    step(1'b1, 32'h4200BC00, HALF_MODE, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b1, 32'h40490FDB, SINGLE_MODE, 1'b0);
    step(1'b1, 32'h40490FDB, SINGLE_MODE, 1'b1);
    step(1'b1, 32'h40490FDB, SINGLE_MODE, 1'b1);
    drain();

    // Back-to-back singles
    for (int i = 0; i < 8; i++) step(1'b1, 32'h3F800000 + 32'(i) * 32'h00800000, SINGLE_MODE, 1'b1);
    drain();

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      step(1'(($urandom_range(0, 3) != 0)), rand_word(), 1'($urandom_range(0, 1)),
           1'(($urandom_range(0, 3) != 0)));
    end
    drain();

    // Reset while presenting the lo half
    step(1'b1, 32'h3C00BC00, HALF_MODE, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_valid", 64'(out_valid), 64'd0);
    check("midrst_ready", 64'(in_ready), 64'd1);
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) step(1'b0, 32'h0, SINGLE_MODE, 1'b1);
    step(1'b1, 32'h3F800000, SINGLE_MODE, 1'b1);
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
